// File: rtl/result_drain.sv
// Drains the CPU result stack into framed bytes on a valid/ready link.
// A nonzero trap code produces one trap frame, after which the block halts until reset.
module result_drain #(
    parameter int unsigned BYTES = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      result,
    input  logic             result_empty,
    output logic             result_pop,
    input  logic [3:0]       trap,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             halted,
    output logic [CNT_W-1:0] frame_count
);

    localparam int unsigned BCNT_W   = 3;
    localparam logic [7:0]  HDR_BYTE = 8'hA0 | 8'(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_TRAP,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [63:0]         shift_q, shift_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [3:0]          trap_q, trap_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                halted_q, halted_d;
    logic                pop_c;
    logic                xfer_c;

    assign xfer_c = valid_q & byte_ready;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcnt_q   <= '0;
            trap_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            trap_q   <= trap_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            halted_q <= halted_d;
        end
    end

    // Next state; stream outputs are derived from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        trap_d   = trap_q;
        count_d  = count_q;
        pop_c    = 1'b0;
        valid_d  = 1'b0;
        data_d   = 8'h00;
        halted_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trap != 4'h0) begin
                    trap_d  = trap;
                    state_d = S_TRAP;
                end else if (!result_empty) begin
                    shift_d = result;
                    pop_c   = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer_c) begin
                    bcnt_d  = BCNT_W'(BYTES - 1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    shift_d = {8'h00, shift_q[63:8]};
                    if (bcnt_q == '0) begin
                        count_d = count_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q - BCNT_W'(1);
                    end
                end
            end
            S_TRAP: begin
                if (xfer_c) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_HDR: begin
                valid_d = 1'b1;
                data_d  = HDR_BYTE;
            end
            S_DATA: begin
                valid_d = 1'b1;
                data_d  = shift_d[7:0];
            end
            S_TRAP: begin
                valid_d = 1'b1;
                data_d  = 8'hF0 | {4'h0, trap_d};
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // The CPU drops its top entry on the same edge, so the pop is a same-cycle strobe
    assign result_pop  = pop_c & reset;
    assign byte_valid  = valid_q;
    assign byte_data   = data_q;
    assign halted      = halted_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: an 8-byte instance and a 2-byte instance
// share clock, reset and byte_ready; expected bytes are written out by hand.
module tb_result_drain;

    localparam logic [3:0]  TM  = 4'h3;
    localparam logic [63:0] R2A = 64'hDEAD_BEEF_CAFE_1122;
    localparam logic [63:0] R2B = 64'h0BAD_F00D_0000_3344;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] result;
    logic        result_empty;
    logic        result_pop;
    logic [3:0]  trap;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        halted;
    logic [15:0] frame_count;

    logic [63:0] result2;
    logic        empty2;
    logic        pop2;
    logic [3:0]  trap2;
    logic [7:0]  byte_data2;
    logic        byte_valid2;
    logic        halted2;
    logic [15:0] fc2;

    int          npass = 0;
    int          nfail = 0;
    int          ntot  = 0;
    int          pops1 = 0;
    int          idx2  = 0;
    bit          en2   = 1'b0;
    logic [7:0]  exp_b [16];

    always #5 clk = ~clk;

    result_drain #(.BYTES(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
        .result_pop(result_pop), .trap(trap), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .halted(halted),
        .frame_count(frame_count)
    );

    result_drain #(.BYTES(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .result(result2), .result_empty(empty2),
        .result_pop(pop2), .trap(trap2), .byte_data(byte_data2),
        .byte_valid(byte_valid2), .byte_ready(byte_ready), .halted(halted2),
        .frame_count(fc2)
    );

    // Two-entry CPU stack for the 2-byte instance
    assign result2 = (idx2 == 0) ? R2A : R2B;
    assign empty2  = !en2 || (idx2 >= 2);

    always @(posedge clk) begin
        if (result_pop) pops1 <= pops1 + 1;
        if (pop2) idx2 <= idx2 + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h required %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; receives n bytes matching exp_b, optionally toggling ready 1,0,0
    task automatic recv(input int n, input bit sel, input bit bp, input int trap_at,
                        input string tag, output int cycles);
        int got = 0;
        int guard = 0;
        int ph = 0;
        bit have_held = 1'b0;
        logic [7:0] held = 8'h00;
        logic v;
        logic [7:0] d;
        while (got < n && guard < 200) begin
            byte_ready = bp ? (ph % 3 == 0) : 1'b1;
            ph++;
            v = sel ? byte_valid2 : byte_valid;
            d = sel ? byte_data2 : byte_data;
            if (v && trap_at >= 0 && got == trap_at) trap = TM;
            if (v) begin
                if (have_held) check({tag, "_hold"}, {56'h0, d}, {56'h0, held});
                if (byte_ready) begin
                    check($sformatf("%s_b%0d", tag, got), {56'h0, d}, {56'h0, exp_b[got]});
                    got++;
                    have_held = 1'b0;
                end else begin
                    held = d;
                    have_held = 1'b1;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (got < n) check({tag, "_timeout"}, 64'(got), 64'(n));
        byte_ready = 1'b1;
        cycles = guard;
    endtask

    initial begin
        int cyc;
        int p0;
        reset        = 1'b0;
        result       = 64'h0;
        result_empty = 1'b1;
        trap         = 4'h0;
        trap2        = 4'h0;
        byte_ready   = 1'b1;

        // Reset state, including pop suppression while in reset
        @(negedge clk);
        result_empty = 1'b0;
        #1;
        check("rst_valid",  {63'h0, byte_valid}, 64'h0);
        check("rst_data",   {56'h0, byte_data},  64'h0);
        check("rst_halted", {63'h0, halted},     64'h0);
        check("rst_fc",     {48'h0, frame_count}, 64'h0);
        check("rst_pop",    {63'h0, result_pop}, 64'h0);
        result_empty = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_valid", {63'h0, byte_valid}, 64'h0);

        // Single result, sink always ready
        exp_b[0] = 8'hA8; exp_b[1] = 8'hEF; exp_b[2] = 8'hCD; exp_b[3] = 8'hAB;
        exp_b[4] = 8'h89; exp_b[5] = 8'h67; exp_b[6] = 8'h45; exp_b[7] = 8'h23;
        exp_b[8] = 8'h01;
        result = 64'h0123_4567_89AB_CDEF;
        result_empty = 1'b0;
        #1;
        check("t1_pop", {63'h0, result_pop}, 64'h1);
        @(negedge clk);
        result_empty = 1'b1;
        recv(9, 1'b0, 1'b0, -1, "t1", cyc);
        check("t1_cycles", 64'(cyc), 64'd9);
        check("t1_valid",  {63'h0, byte_valid}, 64'h0);
        check("t1_fc",     {48'h0, frame_count}, 64'd1);
        check("t1_halted", {63'h0, halted}, 64'h0);
        check("t1_pops",   64'(pops1), 64'd1);

        // Backpressure: identical bytes, held while not ready, one pop
        result_empty = 1'b0;
        @(negedge clk);
        result_empty = 1'b1;
        recv(9, 1'b0, 1'b1, -1, "t2", cyc);
        @(negedge clk);
        check("t2_valid", {63'h0, byte_valid}, 64'h0);
        check("t2_fc",    {48'h0, frame_count}, 64'd2);
        check("t2_pops",  64'(pops1), 64'd2);

        // Two queued results on the 2-byte instance
        exp_b[0] = 8'hA2; exp_b[1] = 8'h22; exp_b[2] = 8'h11;
        exp_b[3] = 8'hA2; exp_b[4] = 8'h44; exp_b[5] = 8'h33;
        en2 = 1'b1;
        #1;
        check("t5_pop", {63'h0, pop2}, 64'h1);
        @(negedge clk);
        recv(6, 1'b1, 1'b0, -1, "t5", cyc);
        check("t5_pops",  64'(idx2), 64'd2);
        check("t5_fc",    {48'h0, fc2}, 64'd2);
        check("t5_valid", {63'h0, byte_valid2}, 64'h0);

        // Trap raised during the third data byte: frame finishes, then trap frame
        exp_b[0] = 8'hA8; exp_b[1] = 8'h44; exp_b[2] = 8'h44; exp_b[3] = 8'h33;
        exp_b[4] = 8'h33; exp_b[5] = 8'h22; exp_b[6] = 8'h22; exp_b[7] = 8'h11;
        exp_b[8] = 8'h11; exp_b[9] = 8'hF3;
        p0 = pops1;
        result = 64'h1111_2222_3333_4444;
        result_empty = 1'b0;
        @(negedge clk);
        result_empty = 1'b1;
        recv(10, 1'b0, 1'b0, 3, "t4", cyc);
        check("t4_fc",     {48'h0, frame_count}, 64'd4);
        check("t4_halted", {63'h0, halted}, 64'h1);
        check("t4_pops",   64'(pops1 - p0), 64'd1);
        result_empty = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_inert_valid", {63'h0, byte_valid}, 64'h0);
        check("t4_inert_pops",  64'(pops1 - p0), 64'd1);

        // Asynchronous reset mid-frame, then stay idle
        trap = 4'h0;
        result_empty = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        p0 = pops1;
        result = 64'h0123_4567_89AB_CDEF;
        result_empty = 1'b0;
        @(negedge clk);
        result_empty = 1'b1;
        @(negedge clk);
        check("t6_pre_valid", {63'h0, byte_valid}, 64'h1);
        check("t6_pre_data",  {56'h0, byte_data}, 64'hEF);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", {63'h0, byte_valid}, 64'h0);
        check("t6_rst_fc",    {48'h0, frame_count}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_valid", {63'h0, byte_valid}, 64'h0);
        check("t6_idle_pops",  64'(pops1 - p0), 64'd1);
        check("t6_idle_fc",    {48'h0, frame_count}, 64'h0);

        // Trap while idle with a pending result: trap wins, no pop
        exp_b[0] = 8'hF3;
        p0 = pops1;
        result_empty = 1'b0;
        trap = TM;
        #1;
        check("t3_nopop", {63'h0, result_pop}, 64'h0);
        @(negedge clk);
        recv(1, 1'b0, 1'b0, -1, "t3", cyc);
        check("t3_halted", {63'h0, halted}, 64'h1);
        check("t3_fc",     {48'h0, frame_count}, 64'd1);
        trap = 4'h5;
        @(negedge clk);
        trap = 4'h0;
        repeat (3) @(negedge clk);
        check("t3_inert_valid", {63'h0, byte_valid}, 64'h0);
        check("t3_inert_pops",  64'(pops1 - p0), 64'd0);
        check("t3_inert_fc",    {48'h0, frame_count}, 64'd1);
        check("t3_inert_halt",  {63'h0, halted}, 64'h1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
